ram_result_reader: RTL and testbench

- Read-back engine for the ALU result RAM.
- On a start command, walks a contiguous window of result-RAM addresses through the RAM read port (r_en/addr_r, data returned on s_RAM).
- Presents each word on a valid/ready output stream, tagged with its address.
- Counts zero-valued results, mirroring the ALU ZF flag over the whole window.

---
 rtl/ram_result_reader.sv | 138 +++++++++++++
 tb/tb_ram_result_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_result_reader.sv
// Read-back engine for the ALU result RAM: walks an address window,
// streams each word out with its address and counts zero results.
module ram_result_reader #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic          r_en,
    output logic [AW-1:0] addr_r,
    input  logic [DW-1:0] s_RAM,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   zero_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    localparam logic [1:0]    LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [1:0]    LAT_ONE  = 2'd1;
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [AW-1:0] cur_addr_q;
    logic [AW:0]   rem_q;
    logic [1:0]    lat_q;
    logic          r_en_q;
    logic [AW-1:0] addr_r_q;
    logic [DW-1:0] out_data_q;
    logic [AW-1:0] out_addr_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;
    logic [AW:0]   zero_cnt_q;

    // Window sequencer; every output is a register set on state entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            lat_q       <= '0;
            r_en_q      <= 1'b0;
            addr_r_q    <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        zero_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        if (count != '0) begin
                            cur_addr_q <= base_addr;
                            rem_q      <= count;
                            r_en_q     <= 1'b1;
                            addr_r_q   <= base_addr;
                            state_q    <= ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    r_en_q  <= 1'b0;
                    lat_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        out_data_q  <= s_RAM;
                        out_addr_q  <= cur_addr_q;
                        out_valid_q <= 1'b1;
                        if (s_RAM == '0) begin
                            zero_cnt_q <= zero_cnt_q + CNT_ONE;
                        end
                        state_q <= PRESENT;
                    end else begin
                        lat_q <= lat_q + LAT_ONE;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        rem_q       <= rem_q - CNT_ONE;
                        cur_addr_q  <= cur_addr_q + ADR_ONE;
                        if (rem_q > CNT_ONE) begin
                            r_en_q   <= 1'b1;
                            addr_r_q <= cur_addr_q + ADR_ONE;
                            state_q  <= ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r_en      = r_en_q;
    assign addr_r    = addr_r_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign zero_cnt  = zero_cnt_q;

endmodule

// File: tb/tb_ram_result_reader.sv
// Directed bench for ram_result_reader: one RD_LAT=1 and one
// RD_LAT=3 instance, each fed by a RAM model sharing one array.
module tb_ram_result_reader;

    localparam logic [31:0] FILL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem [16];

    logic        a_start = 1'b0;
    logic [3:0]  a_base = '0;
    logic [4:0]  a_count = '0;
    logic        a_ren;
    logic [3:0]  a_addr_r;
    logic [31:0] a_sram;
    logic [31:0] a_data;
    logic [3:0]  a_oaddr;
    logic        a_valid;
    logic        a_ready = 1'b0;
    logic        a_busy;
    logic        a_done;
    logic [4:0]  a_zc;

    logic        b_start = 1'b0;
    logic [3:0]  b_base = '0;
    logic [4:0]  b_count = '0;
    logic        b_ren;
    logic [3:0]  b_addr_r;
    logic [31:0] b_sram;
    logic [31:0] b_data;
    logic [3:0]  b_oaddr;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic        b_busy;
    logic        b_done;
    logic [4:0]  b_zc;

    logic [31:0] b_p0, b_p1, b_p2;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_result_reader #(.DW(32), .AW(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .base_addr(a_base), .count(a_count),
        .r_en(a_ren), .addr_r(a_addr_r), .s_RAM(a_sram),
        .out_data(a_data), .out_addr(a_oaddr),
        .out_valid(a_valid), .out_ready(a_ready),
        .busy(a_busy), .done(a_done), .zero_cnt(a_zc)
    );

    ram_result_reader #(.DW(32), .AW(4), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .base_addr(b_base), .count(b_count),
        .r_en(b_ren), .addr_r(b_addr_r), .s_RAM(b_sram),
        .out_data(b_data), .out_addr(b_oaddr),
        .out_valid(b_valid), .out_ready(b_ready),
        .busy(b_busy), .done(b_done), .zero_cnt(b_zc)
    );

    // RAM models: filler value outside the exact read-latency slot
    always @(posedge clk) begin
        a_sram <= a_ren ? mem[a_addr_r] : FILL;
        b_p0   <= b_ren ? mem[b_addr_r] : FILL;
        b_p1   <= b_p0;
        b_p2   <= b_p1;
    end
    assign b_sram = b_p2;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
        mem[2] = 32'h5;
        mem[3] = 32'h0;
        mem[4] = 32'hFFFF_FFFF;
    endtask

    task automatic start_a(input logic [3:0] b, input logic [4:0] c);
        a_base = b;
        a_count = c;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic start_b(input logic [3:0] b, input logic [4:0] c);
        b_base = b;
        b_count = c;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [35:0] q[$];
        logic [3:0]  ea;
        int          ndone;
        int          nwords;
        bit          seen;

        init_mem();
        tick();
        tick();
        chk("rst_ren", a_ren, 0);
        chk("rst_addr_r", a_addr_r, 0);
        chk("rst_data", a_data, 0);
        chk("rst_oaddr", a_oaddr, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_zc", a_zc, 0);
        rst_n = 1'b1;
        tick();

        // basic window
        a_ready = 1'b1;
        start_a(4'd2, 5'd3);
        for (int k = 1; k <= 10; k++) begin
            chk("t1_ren", a_ren, (k == 1 || k == 4 || k == 7));
            chk("t1_valid", a_valid, (k == 3 || k == 6 || k == 9));
            chk("t1_done", a_done, (k == 10));
            chk("t1_busy", a_busy, 1);
            if (k == 3) begin
                chk("t1_d0", a_data, 32'h5);
                chk("t1_a0", a_oaddr, 4'd2);
            end
            if (k == 6) begin
                chk("t1_d1", a_data, 32'h0);
                chk("t1_a1", a_oaddr, 4'd3);
            end
            if (k == 9) begin
                chk("t1_d2", a_data, 32'hFFFF_FFFF);
                chk("t1_a2", a_oaddr, 4'd4);
            end
            if (k < 10) tick();
        end
        chk("t1_zc", a_zc, 1);
        tick();
        chk("t1_idle_busy", a_busy, 0);

        // address wrap
        ndone = 0;
        start_a(4'hE, 5'd4);
        for (int k = 1; k <= 14; k++) begin
            chk("t2_ren", a_ren, (k % 3 == 1 && k <= 10));
            if (k % 3 == 1 && k <= 10) begin
                ea = 4'(14 + (k - 1) / 3);
                chk("t2_addr_r", a_addr_r, ea);
            end
            chk("t2_valid", a_valid, (k % 3 == 0 && k <= 12));
            if (k % 3 == 0 && k <= 12) begin
                ea = 4'(14 + k / 3 - 1);
                chk("t2_oaddr", a_oaddr, ea);
                chk("t2_data", a_data, mem[ea]);
            end
            if (a_done) ndone++;
            chk("t2_done", a_done, (k == 13));
            tick();
        end
        chk("t2_done_once", ndone, 1);
        chk("t2_zc", a_zc, 0);

        // back-pressure on the second word
        q.delete();
        start_a(4'd2, 5'd3);
        for (int k = 1; k <= 15; k++) begin
            a_ready = !(k >= 6 && k <= 10);
            chk("t3_ren", a_ren, (k == 1 || k == 4 || k == 12));
            chk("t3_valid", a_valid,
                (k == 3 || (k >= 6 && k <= 11) || k == 14));
            chk("t3_done", a_done, (k == 15));
            if (k >= 6 && k <= 11) begin
                chk("t3_hold_d", a_data, 32'h0);
                chk("t3_hold_a", a_oaddr, 4'd3);
            end
            if (a_valid && a_ready) q.push_back({a_oaddr, a_data});
            if (k < 15) tick();
        end
        a_ready = 1'b1;
        chk("t3_nwords", q.size(), 3);
        if (q.size() == 3) begin
            chk("t3_w0", q[0], {4'd2, 32'h5});
            chk("t3_w1", q[1], {4'd3, 32'h0});
            chk("t3_w2", q[2], {4'd4, 32'hFFFF_FFFF});
        end
        tick();

        // count = 0
        chk("t4a_pre_zc", a_zc, 1);
        start_a(4'd7, 5'd0);
        chk("t4a_done", a_done, 1);
        chk("t4a_busy", a_busy, 1);
        chk("t4a_ren", a_ren, 0);
        chk("t4a_zc", a_zc, 0);
        tick();
        chk("t4a_done2", a_done, 0);
        chk("t4a_busy2", a_busy, 0);
        chk("t4a_ren2", a_ren, 0);
        tick();

        // start while busy is ignored
        start_a(4'd2, 5'd1);
        for (int k = 1; k <= 6; k++) begin
            chk("t4b_ren", a_ren, (k == 1));
            chk("t4b_valid", a_valid, (k == 3));
            chk("t4b_done", a_done, (k == 4));
            chk("t4b_busy", a_busy, (k <= 4));
            if (k == 3) begin
                chk("t4b_data", a_data, 32'h5);
                chk("t4b_oaddr", a_oaddr, 4'd2);
            end
            a_start = (k == 2);
            a_base = 4'd3;
            a_count = 5'd5;
            tick();
            a_start = 1'b0;
        end

        // full 16-word window over zero RAM
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        seen = 1'b0;
        nwords = 0;
        start_a(4'd0, 5'd16);
        for (int n = 0; n < 200; n++) begin
            if (a_done) begin
                seen = 1'b1;
                break;
            end
            if (a_valid && a_ready) nwords++;
            tick();
        end
        chk("t4c_done_seen", seen, 1);
        chk("t4c_nwords", nwords, 16);
        chk("t4c_zc", a_zc, 16);
        tick();

        // reset during PRESENT of word 2
        init_mem();
        mem[1] = 32'h0;
        start_a(4'd1, 5'd3);
        repeat (5) tick();
        a_ready = 1'b0;
        chk("t5_pre_valid", a_valid, 1);
        chk("t5_pre_data", a_data, 32'h5);
        chk("t5_pre_zc", a_zc, 1);
        rst_n = 1'b0;
        tick();
        chk("t5_ren", a_ren, 0);
        chk("t5_addr_r", a_addr_r, 0);
        chk("t5_data", a_data, 0);
        chk("t5_oaddr", a_oaddr, 0);
        chk("t5_valid", a_valid, 0);
        chk("t5_busy", a_busy, 0);
        chk("t5_done", a_done, 0);
        chk("t5_zc", a_zc, 0);
        rst_n = 1'b1;
        a_ready = 1'b1;
        tick();
        chk("t5_idle_busy", a_busy, 0);
        start_a(4'd0, 5'd1);
        chk("t5_n_ren", a_ren, 1);
        chk("t5_n_addr_r", a_addr_r, 0);
        tick();
        tick();
        chk("t5_n_valid", a_valid, 1);
        chk("t5_n_data", a_data, 32'h100);
        chk("t5_n_oaddr", a_oaddr, 0);
        tick();
        chk("t5_n_done", a_done, 1);
        chk("t5_n_zc", a_zc, 0);
        tick();

        // RD_LAT = 3 instance
        b_ready = 1'b1;
        start_b(4'd5, 5'd2);
        for (int k = 1; k <= 12; k++) begin
            chk("t6_ren", b_ren, (k == 1 || k == 6));
            chk("t6_valid", b_valid, (k == 5 || k == 10));
            chk("t6_done", b_done, (k == 11));
            if (k == 5) begin
                chk("t6_d0", b_data, 32'h105);
                chk("t6_a0", b_oaddr, 4'd5);
            end
            if (k == 10) begin
                chk("t6_d1", b_data, 32'h106);
                chk("t6_a1", b_oaddr, 4'd6);
            end
            tick();
        end
        chk("t6_zc", b_zc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
